// File: rtl/bus_ctrl_mslave.sv
// rtl/bus_ctrl_mslave.sv - single-master, multi-slave bus controller with address decode and ack timeout
module bus_ctrl_mslave #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int N_SLAVES  = 4,
    parameter int REGION_AW = 12,
    parameter int TIMEOUT   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    input  logic [DATA_W/8-1:0]          req_wstrb,
    output logic                         rvalid,
    output logic [DATA_W-1:0]            rdata,
    output logic                         rerr,
    output logic [N_SLAVES-1:0]          s_sel,
    output logic                         s_we,
    output logic [REGION_AW-1:0]         s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [DATA_W/8-1:0]          s_wstrb,
    input  logic [N_SLAVES-1:0]          s_ack,
    input  logic [N_SLAVES*DATA_W-1:0]   s_rdata
);

    localparam int IDX_W  = $clog2(N_SLAVES);
    localparam int CNT_W  = $clog2(TIMEOUT);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_next;

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_ready_d;
    logic              rvalid_d;
    logic [DATA_W-1:0] rdata_d;
    logic              rerr_d;
    logic [N_SLAVES-1:0] s_sel_d;
    logic              s_we_d;
    logic [REGION_AW-1:0] s_addr_d;
    logic [DATA_W-1:0] s_wdata_d;
    logic [STRB_W-1:0] s_wstrb_d;

    logic              req_hit;
    logic [IDX_W-1:0]  req_idx;
    logic              ack_hit;
    logic              cnt_last;
    logic [DATA_W-1:0] slave_rdata [N_SLAVES];

    // Everything above the region index must be zero for the address to decode.
    assign req_hit  = ((req_addr >> (REGION_AW + IDX_W)) == '0);
    assign req_idx  = req_addr[REGION_AW +: IDX_W];
    assign ack_hit  = |(s_ack & s_sel);
    assign cnt_last = (cnt_q == CNT_W'(TIMEOUT - 1));

    for (genvar i = 0; i < N_SLAVES; i++) begin : g_rdata
        assign slave_rdata[i] = s_rdata[i*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = req_hit ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (ack_hit || cnt_last) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata;
        rerr_d    = rerr;
        s_sel_d   = s_sel;
        s_we_d    = s_we;
        s_addr_d  = s_addr;
        s_wdata_d = s_wdata;
        s_wstrb_d = s_wstrb;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    idx_d     = req_idx;
                    cnt_d     = '0;
                    s_we_d    = req_we;
                    s_addr_d  = req_addr[REGION_AW-1:0];
                    s_wdata_d = req_wdata;
                    s_wstrb_d = req_wstrb;
                    if (req_hit) begin
                        s_sel_d = N_SLAVES'(1) << req_idx;
                    end else begin
                        rdata_d = '0;
                        rerr_d  = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // An ack on the last permitted cycle takes priority over the timeout.
                if (ack_hit) begin
                    s_sel_d = '0;
                    rerr_d  = 1'b0;
                    rdata_d = s_we ? '0 : slave_rdata[idx_q];
                end else if (cnt_last) begin
                    s_sel_d = '0;
                    rerr_d  = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
        rvalid_d    = (state_next == RESP);
        req_ready_d = (state_next == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= '0;
            cnt_q     <= '0;
            req_ready <= 1'b1;
            rvalid    <= 1'b0;
            rdata     <= '0;
            rerr      <= 1'b0;
            s_sel     <= '0;
            s_we      <= 1'b0;
            s_addr    <= '0;
            s_wdata   <= '0;
            s_wstrb   <= '0;
        end else begin
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            req_ready <= req_ready_d;
            rvalid    <= rvalid_d;
            rdata     <= rdata_d;
            rerr      <= rerr_d;
            s_sel     <= s_sel_d;
            s_we      <= s_we_d;
            s_addr    <= s_addr_d;
            s_wdata   <= s_wdata_d;
            s_wstrb   <= s_wstrb_d;
        end
    end

endmodule

// File: tb/tb_bus_ctrl_mslave.sv
// tb/tb_bus_ctrl_mslave.sv - vector table and randomized checks for bus_ctrl_mslave
module tb_bus_ctrl_mslave;

    localparam int TIMEOUT = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [31:0]  req_addr;
    logic [31:0]  req_wdata;
    logic [3:0]   req_wstrb;
    logic         rvalid;
    logic [31:0]  rdata;
    logic         rerr;
    logic [3:0]   s_sel;
    logic         s_we;
    logic [11:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic [3:0]   s_ack;
    logic [127:0] s_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    bus_ctrl_mslave #(
        .ADDR_W(32), .DATA_W(32), .N_SLAVES(4), .REGION_AW(12), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rvalid(rvalid), .rdata(rdata), .rerr(rerr),
        .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ack(s_ack), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    // d: cycle of s_sel on which the selected slave acks (0 = never);
    // wrong: a different slave acks on every selected cycle.
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          d;
        bit          wrong;
        logic [31:0] srd;
        bit          exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_selc;
        logic [3:0]  exp_sel;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [3:0] wstrb, input int d, input bit wrong,
                                   input logic [31:0] srd);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
        v.d = d; v.wrong = wrong; v.srd = srd;
        if (addr / 32'h4000 != 0) begin
            v.exp_err = 1; v.exp_rdata = 0; v.exp_lat = 1; v.exp_selc = 0; v.exp_sel = 0;
        end else if (d >= 1 && d <= TIMEOUT) begin
            v.exp_err = 0; v.exp_rdata = we ? 32'h0 : srd;
            v.exp_lat = d + 1; v.exp_selc = d; v.exp_sel = 4'(1 << (addr / 32'h1000));
        end else begin
            v.exp_err = 1; v.exp_rdata = 0; v.exp_lat = TIMEOUT + 1;
            v.exp_selc = TIMEOUT; v.exp_sel = 4'(1 << (addr / 32'h1000));
        end
        return v;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int lat = -1;
        int selc = 0;
        int idx;
        bit stable = 1;
        bit ready_low = 1;
        logic [3:0]  sel0 = 0;
        logic [11:0] addr0 = 0;
        logic        we0 = 0;
        logic [3:0]  strb0 = 0;
        logic [31:0] wd0 = 0;
        logic [31:0] got_rdata = 0;
        logic        got_rerr = 0;
        idx = int'(v.addr[13:12]);
        @(negedge clk);
        chk({tag, "_ready_idle"}, req_ready, 1);
        req_valid = 1; req_we = v.we; req_addr = v.addr;
        req_wdata = v.wdata; req_wstrb = v.wstrb;
        for (int i = 0; i < 4; i++) s_rdata[i*32 +: 32] = v.srd ^ (32'h1357_9BDF * (i + 1));
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            req_valid = 0;
            s_ack = 0;
            s_rdata[idx*32 +: 32] = ~v.srd;
            if (rvalid) begin
                lat = c; got_rdata = rdata; got_rerr = rerr;
                break;
            end
            if (req_ready) ready_low = 0;
            if (s_sel != 0) begin
                selc++;
                if (selc == 1) begin
                    sel0 = s_sel; addr0 = s_addr; we0 = s_we; strb0 = s_wstrb; wd0 = s_wdata;
                end else if (s_sel != sel0 || s_addr != addr0 || s_we != we0 ||
                             s_wstrb != strb0 || s_wdata != wd0) begin
                    stable = 0;
                end
                if (v.wrong) s_ack[(idx + 1) % 4] = 1'b1;
                if (selc == v.d) begin
                    s_ack[idx] = 1'b1;
                    s_rdata[idx*32 +: 32] = v.srd;
                end
            end
        end
        chk({tag, "_lat"}, lat, v.exp_lat);
        chk({tag, "_rdata"}, got_rdata, v.exp_rdata);
        chk({tag, "_rerr"}, got_rerr, v.exp_err);
        chk({tag, "_sel"}, sel0, v.exp_sel);
        chk({tag, "_sel_cycles"}, selc, v.exp_selc);
        chk({tag, "_ready_low"}, ready_low, 1);
        if (v.exp_sel != 0) begin
            chk({tag, "_s_addr"}, addr0, v.addr[11:0]);
            chk({tag, "_s_we"}, we0, v.we);
            chk({tag, "_s_wstrb"}, strb0, v.wstrb);
            chk({tag, "_s_wdata"}, wd0, v.wdata);
            chk({tag, "_stable"}, stable, 1);
        end
        @(negedge clk);
        chk({tag, "_pulse"}, rvalid, 0);
        chk({tag, "_ready_back"}, req_ready, 1);
        chk({tag, "_hold"}, {rerr, rdata}, {v.exp_err, v.exp_rdata});
    endtask

    vec_t vecs[10];

    initial begin
        int bad;
        rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
        req_wstrb = 0; s_ack = 0; s_rdata = 0;

        vecs[0] = '{0, 32'h0000_1010, 32'h0, 4'hF, 1, 0, 32'hCAFE_BABE, 0, 32'hCAFE_BABE, 2, 1, 4'b0010};
        vecs[1] = '{1, 32'h0000_3004, 32'h1234_5678, 4'b0011, 5, 0, 32'hDEAD_BEEF, 0, 32'h0, 6, 5, 4'b1000};
        vecs[2] = '{0, 32'h0001_0000, 32'h0, 4'hF, 1, 0, 32'h1111_1111, 1, 32'h0, 1, 0, 4'b0000};
        vecs[3] = '{0, 32'h0000_2000, 32'h0, 4'hF, 0, 0, 32'h2222_2222, 1, 32'h0, 17, 16, 4'b0100};
        vecs[4] = '{0, 32'h0000_2008, 32'h0, 4'hF, 16, 0, 32'h3333_3333, 0, 32'h3333_3333, 17, 16, 4'b0100};
        vecs[5] = '{0, 32'h0000_0020, 32'h0, 4'hF, 4, 1, 32'h4444_4444, 0, 32'h4444_4444, 5, 4, 4'b0001};
        vecs[6] = '{1, 32'h0000_0FFC, 32'hAAAA_5555, 4'hF, 2, 1, 32'h5555_5555, 0, 32'h0, 3, 2, 4'b0001};
        vecs[7] = '{0, 32'h0000_3FFF, 32'h0, 4'hF, 17, 0, 32'h6666_6666, 1, 32'h0, 17, 16, 4'b1000};
        vecs[8] = '{1, 32'h8000_0000, 32'h0BAD_F00D, 4'hF, 1, 0, 32'h7777_7777, 1, 32'h0, 1, 0, 4'b0000};
        vecs[9] = '{0, 32'h0000_4000, 32'h0, 4'hF, 1, 0, 32'h8888_8888, 1, 32'h0, 1, 0, 4'b0000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rerr", rerr, 0);
        chk("rst_sel", s_sel, 0);
        chk("rst_s_bus", {s_we, s_addr, s_wdata, s_wstrb}, 0);
        rst = 0;

        for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset while a slave is mid-access: transfer vanishes without a response.
        @(negedge clk);
        req_valid = 1; req_we = 0; req_addr = 32'h0000_2010;
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            req_valid = 0;
        end
        chk("abort_sel_before", s_sel, 4'b0100);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_sel", s_sel, 0);
        chk("abort_rvalid", rvalid, 0);
        chk("abort_ready", req_ready, 1);
        rst = 0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (rvalid || s_sel != 0) bad++;
        end
        chk("abort_quiet", bad, 0);
        run_txn(vecs[0], "after_abort");

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            vec_t v;
            if ($urandom_range(0, 4) == 0) a = $urandom | 32'h0000_4000;
            else a = {18'h0, 2'($urandom_range(0, 3)), 12'($urandom)};
            v = model(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 20),
                      1'($urandom), $urandom);
            run_txn(v, $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
